blinky_pwm: RTL

BLINKY_PWM -- requirements
Module: blinky_pwm

---
 rtl/blinky_pwm.sv | 98 +++++++++
 1 files changed

// File: rtl/blinky_pwm.sv
// blinky_pwm: multi-channel LED pattern generator (off/on/blink/breathe) with shared PWM.
module blinky_pwm #(
    parameter int CLK_HZ   = 48000000,
    parameter int TICK_HZ  = 1000,
    parameter int CHANNELS = 3,
    parameter int PWM_BITS = 8
) (
    input  logic                CLK_48,
    input  logic                RST,
    input  logic                CFG_WE,
    input  logic [3:0]          CFG_CH,
    input  logic [1:0]          CFG_MODE,
    input  logic [PWM_BITS-1:0] CFG_LEVEL,
    input  logic [15:0]         CFG_PERIOD,
    output logic                CFG_ACK,
    output logic                CFG_ERR,
    output logic [CHANNELS-1:0] LED_N,
    output logic                TICK
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [1:0] M_OFF = 2'd0;
    localparam logic [1:0] M_ON = 2'd1;
    localparam logic [1:0] M_BLINK = 2'd2;
    localparam logic [1:0] M_BREATHE = 2'd3;

    logic [PW-1:0]       pre;
    logic [PWM_BITS-1:0] pwm;
    logic [1:0]          mode   [CHANNELS];
    logic [PWM_BITS-1:0] level  [CHANNELS];
    logic [PWM_BITS-1:0] b      [CHANNELS];
    logic [PWM_BITS-1:0] duty   [CHANNELS];
    logic [15:0]         period [CHANNELS];
    logic [15:0]         phase  [CHANNELS];
    logic [15:0]         p_eff  [CHANNELS];
    logic [CHANNELS-1:0] down;
    logic [CHANNELS-1:0] wrap;
    logic [CHANNELS-1:0] lit;

    assign TICK = pre == PW'(DIV - 1);

    always_comb begin
        wrap = '0;
        lit = '0;
        p_eff = '{default: '0};
        duty = '{default: '0};
        for (int i = 0; i < CHANNELS; i++) begin
            p_eff[i] = period[i] == 16'd0 ? 16'd1 : period[i];
            wrap[i] = phase[i] == p_eff[i] - 16'd1;
            // Blink is lit for the first half of the period, rounded up.
            duty[i] = mode[i] == M_ON ? level[i] :
                      mode[i] == M_BLINK ? (({1'b0, phase[i]} < (({1'b0, p_eff[i]} + 17'd1) >> 1)) ? level[i] : '0) :
                      mode[i] == M_BREATHE ? b[i] : '0;
            lit[i] = pwm < duty[i];
        end
    end

    always_ff @(posedge CLK_48) begin
        if (RST) begin
            pre <= '0;
            pwm <= '0;
            CFG_ACK <= 1'b0;
            CFG_ERR <= 1'b0;
            LED_N <= '1;
            down <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                mode[i] <= M_OFF;
                level[i] <= '0;
                period[i] <= '0;
                phase[i] <= '0;
                b[i] <= '0;
            end
        end else begin
            pre <= TICK ? '0 : pre + 1'b1;
            pwm <= pwm + 1'b1;
            CFG_ACK <= CFG_WE;
            CFG_ERR <= CFG_WE && (int'(CFG_CH) >= CHANNELS);
            LED_N <= ~lit;
            for (int i = 0; i < CHANNELS; i++) begin
                if (CFG_WE && CFG_CH == 4'(i)) begin
                    mode[i] <= CFG_MODE;
                    level[i] <= CFG_LEVEL;
                    period[i] <= CFG_PERIOD;
                    phase[i] <= '0;
                    b[i] <= '0;
                    down[i] <= 1'b0;
                end else if (TICK) begin
                    phase[i] <= wrap[i] ? '0 : phase[i] + 16'd1;
                    if (wrap[i] && mode[i] == M_BREATHE && level[i] != '0) begin
                        b[i] <= down[i] ? b[i] - 1'b1 : b[i] + 1'b1;
                        if (down[i] ? b[i] == PWM_BITS'(1) : b[i] + 1'b1 == level[i])
                            down[i] <= ~down[i];
                    end
                end
            end
        end
    end
endmodule
